// File: rtl/serial_tl_pkg.sv
// Shared types and constants for the host end of the serial TileLink link.
package serial_tl_pkg;

    localparam int SERIAL_TL_W = 32;

    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_e;

endpackage

// File: rtl/serial_tl_host_phy_if.sv
// Host-side word handshakes plus board-level serial pins of the link PHY.
interface serial_tl_host_phy_if
    import serial_tl_pkg::*;
#(
    parameter int W = SERIAL_TL_W
);

    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] tx_bits;
    logic         rx_valid;
    logic         rx_ready;
    logic [W-1:0] rx_bits;
    logic         serial_in_valid;
    logic         serial_in_ready;
    logic         serial_in_bits;
    logic         serial_out_valid;
    logic         serial_out_ready;
    logic         serial_out_bits;

    // PHY side
    modport slave (
        input  tx_valid,
        output tx_ready,
        input  tx_bits,
        output rx_valid,
        input  rx_ready,
        output rx_bits,
        output serial_in_valid,
        input  serial_in_ready,
        output serial_in_bits,
        input  serial_out_valid,
        output serial_out_ready,
        input  serial_out_bits
    );

    // Host bridge / chip side
    modport master (
        output tx_valid,
        input  tx_ready,
        output tx_bits,
        input  rx_valid,
        output rx_ready,
        input  rx_bits,
        input  serial_in_valid,
        output serial_in_ready,
        input  serial_in_bits,
        output serial_out_valid,
        input  serial_out_ready,
        output serial_out_bits
    );

endinterface

// File: rtl/serial_tl_deser.sv
// RX path: assembles LSB-first serial beats into words behind a one-word holding register.
module serial_tl_deser
    import serial_tl_pkg::*;
#(
    parameter int W  = SERIAL_TL_W,
    parameter int CW = $clog2(W)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         svalid_i,
    input  logic         sbit_i,
    output logic         sready_o,
    output logic         rx_valid_o,
    input  logic         rx_ready_i,
    output logic [W-1:0] rx_bits_o
);

    logic [W-1:0]  asm_q, asm_d;
    logic [W-1:0]  hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic          last;
    logic          beat;
    logic [W-1:0]  shifted;

    assign last     = (cnt_q == CW'(W - 1));
    // Stall only when this bit would finish a word with nowhere to put it
    assign sready_o = !(vld_q && last);
    assign beat     = svalid_i && sready_o;
    assign shifted  = {sbit_i, asm_q[W-1:1]};

    assign rx_valid_o = vld_q;
    assign rx_bits_o  = hold_q;

    always_comb begin
        asm_d  = asm_q;
        hold_d = hold_q;
        cnt_d  = cnt_q;
        vld_d  = vld_q;
        if (vld_q && rx_ready_i) begin
            vld_d = 1'b0;
        end
        if (beat) begin
            asm_d = shifted;
            if (last) begin
                cnt_d  = '0;
                hold_d = shifted;
                vld_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            asm_q  <= '0;
            hold_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

endmodule

// File: rtl/serial_tl_host_phy.sv
// Host end of the 1-bit serial TileLink link: word serializer (TX) and deserializer (RX).
module serial_tl_host_phy
    import serial_tl_pkg::*;
#(
    parameter int W  = SERIAL_TL_W,
    parameter int CW = $clog2(W)
) (
    input logic                 clock,
    input logic                 reset,
    serial_tl_host_phy_if.slave bus
);

    tx_state_e     state_q, state_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    assign last = (cnt_q == CW'(W - 1));

    always_comb begin
        state_d             = state_q;
        sr_d                = sr_q;
        cnt_d               = cnt_q;
        bus.tx_ready        = 1'b0;
        bus.serial_in_valid = 1'b0;
        bus.serial_in_bits  = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.tx_ready = 1'b1;
                if (bus.tx_valid) begin
                    sr_d    = bus.tx_bits;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bus.serial_in_valid = 1'b1;
                bus.serial_in_bits  = sr_q[0];
                if (bus.serial_in_ready) begin
                    sr_d  = sr_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                    // Last beat: accept the next word now so there is no gap cycle
                    if (last) begin
                        bus.tx_ready = 1'b1;
                        cnt_d        = '0;
                        if (bus.tx_valid) begin
                            sr_d = bus.tx_bits;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    serial_tl_deser #(
        .W  (W),
        .CW (CW)
    ) u_deser (
        .clock      (clock),
        .reset      (reset),
        .svalid_i   (bus.serial_out_valid),
        .sbit_i     (bus.serial_out_bits),
        .sready_o   (bus.serial_out_ready),
        .rx_valid_o (bus.rx_valid),
        .rx_ready_i (bus.rx_ready),
        .rx_bits_o  (bus.rx_bits)
    );

endmodule

// File: tb/tb_serial_tl_host_phy.sv
// Directed bench for serial_tl_host_phy: TX/RX words, back-to-back, backpressure, stall, reset.
module tb_serial_tl_host_phy;
    import serial_tl_pkg::*;

    localparam int W = 32;

    logic clock = 1'b0;
    logic reset;
    int   nerr = 0;
    int   nchk = 0;
    logic [W-1:0] w;
    logic [W-1:0] a;
    logic [W-1:0] b;

    serial_tl_host_phy_if #(.W(W)) bus ();

    serial_tl_host_phy #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_tx_ready"}, bus.tx_ready, 1);
        chk({tag, "_siv"}, bus.serial_in_valid, 0);
        chk({tag, "_sib"}, bus.serial_in_bits, 0);
        chk({tag, "_sor"}, bus.serial_out_ready, 1);
        chk({tag, "_rx_valid"}, bus.rx_valid, 0);
        chk({tag, "_rx_bits"}, bus.rx_bits, 0);
    endtask

    initial begin
        reset                = 1'b1;
        bus.tx_valid         = 1'b0;
        bus.tx_bits          = '0;
        bus.rx_ready         = 1'b0;
        bus.serial_in_ready  = 1'b0;
        bus.serial_out_valid = 1'b0;
        bus.serial_out_bits  = 1'b0;

        @(negedge clock);
        #1 chk_reset_outs("reset");
        @(negedge clock);
        reset = 1'b0;

        // Single TX word
        @(negedge clock);
        w = 32'hA5A5_0F0F;
        bus.tx_valid = 1'b1;
        bus.tx_bits = w;
        bus.serial_in_ready = 1'b1;
        #1 chk("t1_accept_ready", bus.tx_ready, 1);
        @(negedge clock);
        bus.tx_valid = 1'b0;
        bus.tx_bits = '0;
        for (int i = 0; i < W; i++) begin
            #1;
            chk("t1_siv", bus.serial_in_valid, 1);
            chk("t1_sib", bus.serial_in_bits, w[i]);
            chk("t1_tx_ready", bus.tx_ready, (i == W - 1) ? 1 : 0);
            @(negedge clock);
        end
        #1;
        chk("t1_idle_siv", bus.serial_in_valid, 0);
        chk("t1_idle_ready", bus.tx_ready, 1);

        // Back-to-back TX words
        @(negedge clock);
        bus.tx_valid = 1'b1;
        bus.tx_bits = 32'h0000_0001;
        @(negedge clock);
        bus.tx_bits = 32'h8000_0000;
        for (int i = 0; i < 2 * W; i++) begin
            #1;
            chk("t2_siv", bus.serial_in_valid, 1);
            chk("t2_sib", bus.serial_in_bits, (i == 0 || i == 2 * W - 1) ? 1 : 0);
            if (i == W - 1) chk("t2_reload_ready", bus.tx_ready, 1);
            @(negedge clock);
            if (i == W - 1) bus.tx_valid = 1'b0;
        end
        #1 chk("t2_idle_siv", bus.serial_in_valid, 0);

        // TX backpressure, ready 0101...
        @(negedge clock);
        w = 32'h3C96_5A17;
        bus.tx_valid = 1'b1;
        bus.tx_bits = w;
        @(negedge clock);
        bus.tx_valid = 1'b0;
        for (int k = 0; k < 2 * W; k++) begin
            bus.serial_in_ready = (k % 2 == 1);
            #1;
            chk("t3_siv", bus.serial_in_valid, 1);
            chk("t3_sib", bus.serial_in_bits, w[k/2]);
            chk("t3_tx_ready", bus.tx_ready, (k == 2 * W - 1) ? 1 : 0);
            @(negedge clock);
        end
        bus.serial_in_ready = 1'b1;
        #1 chk("t3_idle_siv", bus.serial_in_valid, 0);

        // Single RX word
        @(negedge clock);
        w = 32'hDEAD_BEEF;
        bus.rx_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            bus.serial_out_valid = 1'b1;
            bus.serial_out_bits = w[i];
            #1;
            chk("t4_sor", bus.serial_out_ready, 1);
            chk("t4_rx_valid_early", bus.rx_valid, 0);
            @(negedge clock);
        end
        bus.serial_out_valid = 1'b0;
        #1;
        chk("t4_rx_valid", bus.rx_valid, 1);
        chk("t4_rx_bits", bus.rx_bits, w);
        @(negedge clock);
        #1 chk("t4_rx_valid_drop", bus.rx_valid, 0);

        // RX stall with holding register occupied
        @(negedge clock);
        a = 32'hCAFE_F00D;
        b = 32'h1234_5678;
        bus.rx_ready = 1'b0;
        for (int i = 0; i < W; i++) begin
            bus.serial_out_valid = 1'b1;
            bus.serial_out_bits = a[i];
            @(negedge clock);
        end
        for (int i = 0; i < W - 1; i++) begin
            bus.serial_out_bits = b[i];
            #1;
            chk("t5_sor_b", bus.serial_out_ready, 1);
            chk("t5_hold_valid", bus.rx_valid, 1);
            chk("t5_hold_bits", bus.rx_bits, a);
            @(negedge clock);
        end
        bus.serial_out_bits = b[W-1];
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall_sor", bus.serial_out_ready, 0);
            chk("t5_stall_bits", bus.rx_bits, a);
            @(negedge clock);
        end
        bus.rx_ready = 1'b1;
        #1;
        chk("t5_no_comb_sor", bus.serial_out_ready, 0);
        chk("t5_pop_bits", bus.rx_bits, a);
        @(negedge clock);
        bus.rx_ready = 1'b0;
        #1;
        chk("t5_popped_valid", bus.rx_valid, 0);
        chk("t5_resume_sor", bus.serial_out_ready, 1);
        @(negedge clock);
        bus.serial_out_valid = 1'b0;
        #1;
        chk("t5_b_valid", bus.rx_valid, 1);
        chk("t5_b_bits", bus.rx_bits, b);
        @(negedge clock);
        #1 chk("t5_b_held", bus.rx_valid, 1);
        bus.rx_ready = 1'b1;
        @(negedge clock);
        #1 chk("t5_b_popped", bus.rx_valid, 0);

        // Reset in the middle of a TX word
        @(negedge clock);
        bus.tx_valid = 1'b1;
        bus.tx_bits = 32'hFFFF_FFFF;
        @(negedge clock);
        bus.tx_valid = 1'b0;
        repeat (10) @(negedge clock);
        #1 chk("t6_pre_sib", bus.serial_in_bits, 1);
        #1 reset = 1'b1;
        #1;
        chk("t6_tx_rst_siv", bus.serial_in_valid, 0);
        chk("t6_tx_rst_sib", bus.serial_in_bits, 0);
        chk("t6_tx_rst_ready", bus.tx_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        w = 32'h0000_00F0;
        bus.tx_valid = 1'b1;
        bus.tx_bits = w;
        @(negedge clock);
        bus.tx_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            #1;
            chk("t6_tx_siv", bus.serial_in_valid, 1);
            chk("t6_tx_sib", bus.serial_in_bits, w[i]);
            @(negedge clock);
        end
        #1 chk("t6_tx_idle", bus.serial_in_valid, 0);

        // Reset in the middle of an RX word
        @(negedge clock);
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.serial_out_valid = 1'b1;
            bus.serial_out_bits = 1'b1;
            @(negedge clock);
        end
        bus.serial_out_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_outs("t6_rx_rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        w = 32'h8765_4321;
        for (int i = 0; i < W; i++) begin
            bus.serial_out_valid = 1'b1;
            bus.serial_out_bits = w[i];
            #1 chk("t6_rx_no_partial", bus.rx_valid, 0);
            @(negedge clock);
        end
        bus.serial_out_valid = 1'b0;
        #1;
        chk("t6_rx_valid", bus.rx_valid, 1);
        chk("t6_rx_bits", bus.rx_bits, w);

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
